// File: rtl/hd44780_rx_pkg.sv
// Shared types and constants for the HD44780 4-bit bus receiver.
package hd44780_rx_pkg;

  typedef enum logic {
    PH_HI = 1'b0,
    PH_LO = 1'b1
  } phase_t;

  localparam logic [7:0] FSET_MASK = 8'hE0;
  localparam logic [7:0] FSET_VAL  = 8'h20;
  localparam int         DL_BIT    = 4;
  localparam logic [3:0] INIT4_NYB = 4'h2;

  // FIFO entry layout: {single, rs, byte}
  localparam int ENTRY_W = 10;

  function automatic logic is_fset(input logic [7:0] b);
    return (b & FSET_MASK) == FSET_VAL;
  endfunction

endpackage

// File: rtl/hd44780_rx_fifo.sv
// Synchronous FIFO with a registered head; total capacity is 2**AW entries
// including the entry currently presented on rdata/valid.
module hd44780_rx_fifo
  import hd44780_rx_pkg::*;
#(
  parameter int AW = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic               pop,
  output logic [ENTRY_W-1:0] rdata,
  output logic               valid,
  output logic               full,
  output logic               empty
);

  localparam int DEPTH = 2 ** AW;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        count;
  logic               do_push;
  logic               do_pop;
  logic [AW-1:0]      rd_nxt;
  logic [AW:0]        kept;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & valid;
  assign do_push = push & (~full | do_pop);
  assign rd_nxt  = rd_ptr + AW'(do_pop);
  // Entries already stored before this edge's write; the head only reloads from these.
  assign kept    = count - (AW+1)'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      rdata  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_nxt;
      count  <= kept + (AW+1)'(do_push);
      valid  <= (kept != '0);
      rdata  <= mem[rd_nxt];
    end
  end

endmodule

// File: rtl/hd44780_bus_receiver.sv
// LCD-side decoder of the HD44780 4-bit write bus into a small handshake FIFO.
// Optional macro HD44780_RX_TIMING_CHECK_EN builds the E width/spacing checker.
module hd44780_bus_receiver
  import hd44780_rx_pkg::*;
#(
  parameter int FIFO_AW     = 2,
  parameter int MIN_E_HIGH  = 6,
  parameter int MIN_E_CYCLE = 12
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       i_e,
  input  logic       i_rs,
  input  logic [3:0] i_nybble,
  output logic       STB_O,
  input  logic       ACK_I,
  output logic [7:0] o_byte,
  output logic       o_rs,
  output logic       o_single,
  output logic       o_mode4,
  input  logic       i_clr_err,
  output logic       o_err_rs,
  output logic       o_err_ovf,
  output logic       o_err_timing
);

  if (MIN_E_HIGH < 1 || MIN_E_CYCLE <= MIN_E_HIGH) begin : g_bad_params
    $error("hd44780_bus_receiver: E timing parameters out of range");
  end

  logic e_p0, e_p1, e_p2;
  logic rs_p0, rs_p1;
  logic [3:0] nyb_p0, nyb_p1;
  logic fall;

  phase_t phase, phase_nxt;
  logic mode4, mode4_nxt;
  logic [3:0] hi, hi_nxt;
  logic hi_rs, hi_rs_nxt;
  logic [7:0] pair;
  logic push, pop, set_rs, set_ovf;
  logic [ENTRY_W-1:0] wdata, rdata;
  logic fifo_full, fifo_empty;
  logic err_rs, err_ovf;

  // Stage p0/p1: two-flop synchroniser; p2 holds previous E for edge detection
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      {e_p0, e_p1, e_p2} <= '0;
      {rs_p0, rs_p1}     <= '0;
      nyb_p0 <= '0;
      nyb_p1 <= '0;
    end else begin
      e_p0   <= i_e;
      e_p1   <= e_p0;
      e_p2   <= e_p1;
      rs_p0  <= i_rs;
      rs_p1  <= rs_p0;
      nyb_p0 <= i_nybble;
      nyb_p1 <= nyb_p0;
    end
  end

  assign fall = e_p2 & ~e_p1;
  assign pair = {hi, nyb_p1};
  assign pop  = ACK_I & STB_O & ~fifo_empty;

  // Stage p2: decode one E fall into a FIFO write and mode/phase updates
  always_comb begin
    phase_nxt = phase;
    mode4_nxt = mode4;
    hi_nxt    = hi;
    hi_rs_nxt = hi_rs;
    push      = 1'b0;
    wdata     = '0;
    set_rs    = 1'b0;
    if (fall) begin
      if (!mode4) begin
        push  = 1'b1;
        wdata = {1'b1, rs_p1, nyb_p1, 4'h0};
        if (!rs_p1 && nyb_p1 == INIT4_NYB) begin
          mode4_nxt = 1'b1;
          phase_nxt = PH_HI;
        end
      end else if (phase == PH_HI) begin
        hi_nxt    = nyb_p1;
        hi_rs_nxt = rs_p1;
        phase_nxt = PH_LO;
      end else begin
        phase_nxt = PH_HI;
        if (rs_p1 == hi_rs) begin
          push  = 1'b1;
          wdata = {1'b0, rs_p1, pair};
          if (!rs_p1 && is_fset(pair)) mode4_nxt = ~pair[DL_BIT];
        end else begin
          set_rs = 1'b1;
        end
      end
    end
  end

  assign set_ovf = push & fifo_full & ~pop;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      phase   <= PH_HI;
      mode4   <= 1'b0;
      hi      <= '0;
      hi_rs   <= 1'b0;
      err_rs  <= 1'b0;
      err_ovf <= 1'b0;
    end else begin
      phase   <= phase_nxt;
      mode4   <= mode4_nxt;
      hi      <= hi_nxt;
      hi_rs   <= hi_rs_nxt;
      err_rs  <= set_rs  | (err_rs  & ~i_clr_err);
      err_ovf <= set_ovf | (err_ovf & ~i_clr_err);
    end
  end

`ifdef HD44780_RX_TIMING_CHECK_EN
  localparam int HW = $clog2(MIN_E_HIGH + 1);
  localparam int CW = $clog2(MIN_E_CYCLE + 1);

  logic [HW-1:0] high_cnt;
  logic [CW-1:0] cyc_cnt;
  logic seen_rise, rise, set_tm, err_timing;

  assign rise   = e_p1 & ~e_p2;
  // The first rise after reset has no predecessor to be measured against.
  assign set_tm = (fall && high_cnt < HW'(MIN_E_HIGH)) ||
                  (rise && seen_rise && cyc_cnt < CW'(MIN_E_CYCLE));

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      high_cnt   <= '0;
      cyc_cnt    <= '0;
      seen_rise  <= 1'b0;
      err_timing <= 1'b0;
    end else begin
      if (rise) high_cnt <= HW'(1);
      else if (e_p1 && high_cnt != HW'(MIN_E_HIGH)) high_cnt <= high_cnt + 1'b1;
      if (rise) begin
        cyc_cnt   <= CW'(1);
        seen_rise <= 1'b1;
      end else if (cyc_cnt != CW'(MIN_E_CYCLE)) begin
        cyc_cnt <= cyc_cnt + 1'b1;
      end
      err_timing <= set_tm | (err_timing & ~i_clr_err);
    end
  end

  assign o_err_timing = err_timing;
`else
  assign o_err_timing = 1'b0;
`endif

  hd44780_rx_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk   (CLK_I),
    .rst   (RST_I),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .valid (STB_O),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign {o_single, o_rs, o_byte} = rdata;
  assign o_mode4   = mode4;
  assign o_err_rs  = err_rs;
  assign o_err_ovf = err_ovf;

endmodule

// File: tb/tb_hd44780_bus_receiver.sv
// Scoreboard bench for hd44780_bus_receiver with a spec-level reference model.
module tb_hd44780_bus_receiver;

`ifdef HD44780_RX_TIMING_CHECK_EN
  localparam bit TM_EN = 1'b1;
`else
  localparam bit TM_EN = 1'b0;
`endif

  logic       CLK_I = 1'b0;
  logic       RST_I = 1'b1;
  logic       i_e = 1'b0;
  logic       i_rs = 1'b0;
  logic [3:0] i_nybble = 4'h0;
  logic       STB_O;
  logic       ACK_I = 1'b1;
  logic [7:0] o_byte;
  logic       o_rs, o_single, o_mode4;
  logic       i_clr_err = 1'b0;
  logic       o_err_rs, o_err_ovf, o_err_timing;

  hd44780_bus_receiver dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .i_e(i_e), .i_rs(i_rs), .i_nybble(i_nybble),
    .STB_O(STB_O), .ACK_I(ACK_I), .o_byte(o_byte), .o_rs(o_rs), .o_single(o_single),
    .o_mode4(o_mode4), .i_clr_err(i_clr_err), .o_err_rs(o_err_rs),
    .o_err_ovf(o_err_ovf), .o_err_timing(o_err_timing)
  );

  always #5 CLK_I = ~CLK_I;

  typedef struct {
    logic [7:0] b;
    logic       rs;
    logic       single;
  } exp_t;

  exp_t sbq[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state (spec-level view of the LCD interface)
  bit m_mode4 = 0, m_have_hi = 0, m_hirs = 0;
  logic [3:0] m_hi = 0;
  bit exp_rs = 0, exp_ovf = 0, exp_tm = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic model_push(input logic [7:0] b, input logic rs, input logic single);
    exp_t e;
    if (sbq.size() >= 4) exp_ovf = 1;
    else begin
      e.b = b; e.rs = rs; e.single = single;
      sbq.push_back(e);
    end
  endtask

  task automatic model_nyb(input logic rs, input logic [3:0] nyb);
    logic [7:0] b;
    if (!m_mode4) begin
      model_push({nyb, 4'h0}, rs, 1'b1);
      if (!rs && nyb == 4'h2) begin m_mode4 = 1; m_have_hi = 0; end
    end else if (!m_have_hi) begin
      m_hi = nyb; m_hirs = rs; m_have_hi = 1;
    end else begin
      m_have_hi = 0;
      if (rs != m_hirs) exp_rs = 1;
      else begin
        b = {m_hi, nyb};
        model_push(b, rs, 1'b0);
        if (!rs && b[7:5] == 3'b001) m_mode4 = !b[4];
      end
    end
  endtask

  task automatic send(input logic rs, input logic [3:0] nyb, input int high, input int gap);
    model_nyb(rs, nyb);
    if (high < 6 && TM_EN) exp_tm = 1;
    @(posedge CLK_I); #1;
    i_rs = rs; i_nybble = nyb; i_e = 1'b1;
    repeat (high) @(posedge CLK_I);
    #1 i_e = 1'b0;
    repeat (gap) @(posedge CLK_I);
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 200 && sbq.size() > 0; i++) @(negedge CLK_I);
    chk("drain_timeout_left", 32'(sbq.size()), 32'd0);
  endtask

  task automatic chk_errs(input string tag);
    @(negedge CLK_I);
    chk({tag, "_err_rs"}, 32'(o_err_rs), 32'(exp_rs));
    chk({tag, "_err_ovf"}, 32'(o_err_ovf), 32'(exp_ovf));
    chk({tag, "_err_timing"}, 32'(o_err_timing), 32'(exp_tm));
  endtask

  // Monitor: pop and compare whenever the DUT hands over an entry
  always @(negedge CLK_I) begin
    if (!RST_I && STB_O && ACK_I) begin
      if (sbq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_entry: got byte %0h, required no entry", o_byte);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("entry_byte", 32'(o_byte), 32'(e.b));
        chk("entry_rs", 32'(o_rs), 32'(e.rs));
        chk("entry_single", 32'(o_single), 32'(e.single));
      end
    end
  end

  initial begin
    logic [7:0] ov [5];
    int stb_cnt, g, h;
    logic r;
    logic [3:0] n;

    // Reset state
    repeat (3) @(posedge CLK_I);
    @(negedge CLK_I);
    chk("rst_stb", 32'(STB_O), 32'd0);
    chk("rst_outputs", 32'({o_byte, o_rs, o_single, o_mode4}), 32'd0);
    chk("rst_errs", 32'({o_err_rs, o_err_ovf, o_err_timing}), 32'd0);
    @(posedge CLK_I); #1 RST_I = 1'b0;

    // Init sequence 3,3,3,2 in 8-bit mode
    send(0, 4'h3, 8, 12); send(0, 4'h3, 8, 12); send(0, 4'h3, 8, 12);
    @(negedge CLK_I); chk("init_mode4_before", 32'(o_mode4), 32'd0);
    send(0, 4'h2, 8, 12);
    @(negedge CLK_I); chk("init_mode4_after", 32'(o_mode4), 32'(m_mode4));
    wait_empty();

    // 4-bit write 41 with STB latency check
    ACK_I = 1'b0;
    send(1, 4'h4, 8, 12);
    send(1, 4'h1, 8, 0);
    repeat (4) @(negedge CLK_I);
    chk("lat_stb_cycle3", 32'(STB_O), 32'd0);
    @(negedge CLK_I);
    chk("lat_stb_cycle4", 32'(STB_O), 32'd1);
    @(posedge CLK_I); #1 ACK_I = 1'b1;
    wait_empty();

    // Function set with DL=1 returns to 8-bit mode, then back to 4-bit
    send(0, 4'h3, 8, 12); send(0, 4'h0, 8, 12);
    @(negedge CLK_I); chk("fset_mode4", 32'(o_mode4), 32'd0);
    send(0, 4'h2, 8, 12);
    @(negedge CLK_I); chk("reinit_mode4", 32'(o_mode4), 32'd1);
    wait_empty();

    // RS mismatch drops the pair; next pair 42 is fine
    send(1, 4'h4, 8, 12); send(0, 4'h1, 8, 12);
    send(1, 4'h4, 8, 12); send(1, 4'h2, 8, 12);
    wait_empty();
    chk_errs("rsmis");

    // Overflow: 5 pairs with no ack
    ACK_I = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ov[i] = 8'($urandom_range(8'h40, 8'hFF));
      send(1, ov[i][7:4], 8, 12); send(1, ov[i][3:0], 8, 12);
    end
    chk_errs("ovf");
    chk("ovf_head_stb", 32'(STB_O), 32'd1);
    chk("ovf_head_byte", 32'(o_byte), 32'(ov[0]));
    @(posedge CLK_I); #1 ACK_I = 1'b1;
    stb_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK_I);
      if (STB_O) stb_cnt++;
    end
    chk("ovf_drain_cycles", 32'(stb_cnt), 32'd4);
    wait_empty();

    // Short E high: data still captured; timing error only with checker built
    send(1, 4'h5, 3, 12); send(1, 4'h7, 8, 12);
    wait_empty();
    chk_errs("timing");
    @(posedge CLK_I); #1 i_clr_err = 1'b1;
    @(posedge CLK_I); #1 i_clr_err = 1'b0;
    exp_rs = 0; exp_ovf = 0; exp_tm = 0;
    chk_errs("clr");

    // Async reset between hi and lo
    send(1, 4'h6, 8, 12);
    @(posedge CLK_I); #3 RST_I = 1'b1;
    m_mode4 = 0; m_have_hi = 0; sbq.delete();
    repeat (2) @(posedge CLK_I);
    #1 RST_I = 1'b0;
    @(negedge CLK_I);
    chk("rst_mid_mode4", 32'(o_mode4), 32'd0);
    chk("rst_mid_stb", 32'(STB_O), 32'd0);
    send(0, 4'h3, 8, 12);
    wait_empty();

    // Randomized transfers against the model
    for (int i = 0; i < 60; i++) begin
      r = 1'($urandom_range(0, 1));
      n = 4'($urandom_range(0, 15));
      h = $urandom_range(6, 10);
      g = 12 - h;
      if (g < 6) g = 6;
      g = g + $urandom_range(0, 3);
      send(r, n, h, g);
      @(negedge CLK_I);
      chk("rand_mode4", 32'(o_mode4), 32'(m_mode4));
    end
    wait_empty();
    chk_errs("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got still running, required finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hd44780_bus_receiver.md
Name: hd44780_bus_receiver

Overview:
LCD-side responder for the HD44780 4-bit write bus driven by hd44780_controller. It samples E, RS and the data nybble as seen on the LCD pins and decodes each E pulse. It tracks the 8-bit/4-bit interface mode through the init sequence and reassembles nybble pairs into bytes. Decoded transfers go into a small FIFO and are offered on a valid/ack handshake, so a bench or an on-chip sniffer can check the instruction stream the controller really emits.

Parameters:
FIFO_AW, 2, log2 of FIFO depth (4 entries)
MIN_E_HIGH, 6, minimum E-high width in CLK_I cycles
MIN_E_CYCLE, 12, minimum E rise-to-rise spacing in CLK_I cycles

Ports:
CLK_I  input  1  system clock
RST_I  input  1  reset, asynchronous, active-high
i_e  input  1  LCD enable pin
i_rs  input  1  LCD register-select pin
i_nybble  input  4  LCD DB7..DB4
STB_O  output  1  FIFO non-empty, head entry valid
ACK_I  input  1  pop head entry; ignored when STB_O=0
o_byte  output  8  head entry data
o_rs  output  1  head entry RS
o_single  output  1  head entry was an 8-bit-mode single-nybble write
o_mode4  output  1  current interface mode, 1 = 4-bit
i_clr_err  input  1  one-cycle pulse, clears all sticky errors
o_err_rs  output  1  sticky: RS differed between the two halves of a pair
o_err_ovf  output  1  sticky: decoded transfer dropped, FIFO full
o_err_timing  output  1  sticky: E width or E spacing violation

Behaviour:
- Reset (async, RST_I=1): all outputs 0, FIFO empty, mode 8-bit, phase=HI, synchroniser flops 0, timing counters 0.
- Inputs pass through a 2-flop synchroniser. E rise/fall is detected from the synchronised E and its previous value.
- RS and the nybble are sampled on the synchronised E falling edge. Pin edge to FIFO write is 3 cycles; STB_O asserts 4 cycles after the pin edge.
- 8-bit mode: every falling edge is one transfer.
  - Write byte = {nybble,4'h0}, o_single=1.
  - If rs=0 and nybble==4'h2, set mode4=1 and phase=HI after the write.
- 4-bit mode: two-state phase FSM.
  - HI: latch hi nybble and rs, go to LO.
  - LO: if rs matches, write {hi,lo} with o_single=0. If rs differs, set err_rs, write nothing. Either way return to HI.
  - A completed write with rs=0 and byte[7:5]==3'b001 (function set) sets mode4 to byte[4]==0.
- FIFO: a write when full drops the entry and sets err_ovf. Push and pop in the same cycle while full succeeds with no overflow. Pop happens when STB_O & ACK_I. Head outputs are registered from the FIFO, with no bubble on back-to-back pops.
- Sticky errors are held until i_clr_err. A set event in the same cycle as i_clr_err wins.
- Reset mid-pair discards the latched hi nybble.
- Timing checks:
  - E-high counter: a falling edge with count < MIN_E_HIGH sets err_timing. The data is still captured.
  - Rise-to-rise counter: saturates at MIN_E_CYCLE. A rise with count < MIN_E_CYCLE sets err_timing. The first rise after reset is exempt.

Optional Feature:
HD44780_RX_TIMING_CHECK_EN: when defined, both timing counters and o_err_timing logic are built as above. When undefined, the counters are absent and o_err_timing is tied 0. All other behaviour is identical.

Decomposition:
- Shared package hd44780_rx_pkg:
  - FSM phase encoding (PH_HI, PH_LO).
  - Function-set mask/pattern constants (FSET_MASK 8'hE0, FSET_VAL 8'h20, DL_BIT 4).
  - Init nybble constant INIT4_NYB 4'h2.
- One sub-module: hd44780_rx_fifo. It is a synchronous FIFO with the same clock and reset, parameter AW, and outputs full/empty.

Test Plan:
- Init sequence: nybbles 3,3,3,2 with rs=0, E high 8, spacing 20. Expect FIFO entries 30,30,30,20, all o_single=1; mode4=1 after the fourth entry.
- 4-bit write in mode4: nybbles 4,1 with rs=1. Expect o_byte=41, o_rs=1, o_single=0, STB_O 4 cycles after the second E fall. Then nybbles 3,0 with rs=0 (function set, DL=1): expect entry 30 and mode4 returning to 0.
- RS mismatch: hi=4 with rs=1, lo=1 with rs=0. Expect err_rs=1, no entry. The next pair 4,2 with rs=1 yields 42.
- Overflow: with ACK_I=0, send 5 pairs. Expect 4 entries, err_ovf=1, first entry still at the head. Then ACK_I held high drains the 4 in 4 consecutive cycles.
- Timing (macro defined): E high 3 cycles gives err_timing=1 and the byte is still captured. i_clr_err clears it. With the macro undefined, the same stimulus leaves err_timing=0.
- Async reset asserted between hi and lo: after release, mode4=0, STB_O=0. A single nybble 3 yields 30 with o_single=1.
